// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between the EX stage and the iterative RV32M multiply/divide unit.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes
// sharing one hi/lo register pair, with sign fix-up folded into the final iteration.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic            sign_a_q, sign_a_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   add_sum, rem_sh, diff;
  logic            q_bit;
  logic [XLEN-1:0] mul_hi, mul_lo, div_hi, div_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] mul_res, div_res;

  // One step of each datapath, evaluated every cycle from the shared hi/lo registers.
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    mul_hi   = add_sum[XLEN:1];
    mul_lo   = {add_sum[0], lo_q[XLEN-1:1]};
    prod     = {mul_hi, mul_lo};
    prod_fix = neg_q ? -prod : prod;
    mul_res  = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    rem_sh   = {hi_q, lo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, b_q};
    q_bit    = ~diff[XLEN];
    div_hi   = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_lo   = {lo_q[XLEN-2:0], q_bit};
    div_res  = f3_q[1] ? (sign_a_q ? -div_hi : div_hi)
                       : (neg_q ? -div_lo : div_lo);
  end

  always_comb begin
    a_sgn = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_sgn = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    sa    = a_sgn & bus.op_a[XLEN-1];
    sb    = b_sgn & bus.op_b[XLEN-1];
    mag_a = sa ? -bus.op_a : bus.op_a;
    mag_b = sb ? -bus.op_b : bus.op_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          f3_d     = bus.funct3;
          sign_a_d = sa;
          neg_d    = sa ^ sb;
          hi_d     = '0;
          lo_d     = mag_a;
          b_d      = mag_b;
          cnt_d    = CW'(XLEN - 1);
          state_d  = bus.funct3[2] ? DIV : MUL;
          if (bus.funct3[2] && bus.op_b == '0) begin
            result_d = bus.funct3[1] ? bus.op_a : '1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (bus.funct3[2] && !bus.funct3[0] &&
                       bus.op_a == MIN_NEG && bus.op_b == '1) begin
            result_d = bus.funct3[1] ? '0 : MIN_NEG;
            done_d   = 1'b1;
            state_d  = DONE;
          end
        end
      end
      MUL, DIV: begin
        hi_d  = (state_q == MUL) ? mul_hi : div_hi;
        lo_d  = (state_q == MUL) ? mul_lo : div_lo;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = (state_q == MUL) ? mul_res : div_res;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A redirect discards whatever was in flight, including a pending result.
    if (bus.flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.stall  = (state_q == IDLE && bus.start && !bus.flush) ||
                      state_q == MUL || state_q == DIV;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q & ~bus.flush;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, fast paths, flush and reset.
module tb_muldiv_sequencer;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    int sc;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL %s accept_stall got %b want 1", name, bus.stall);
    else n_pass++;
    sc = 1;
    @(negedge clk);
    bus.start = 1'b0; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'h1234_5678; bus.funct3 = 3'b111;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.stall === 1'b1) sc++;
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat != exp_lat) $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
    else n_pass++;
    n_total++;
    if (sc != exp_lat) $display("FAIL %s stall_cycles got %0d want %0d", name, sc, exp_lat);
    else n_pass++;
    n_total++;
    if (bus.result !== exp) $display("FAIL %s result got %h want %h", name, bus.result, exp);
    else n_pass++;
    n_total++;
    if (bus.stall !== 1'b0) $display("FAIL %s done_stall got %b want 0", name, bus.stall);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp)
      $display("FAIL %s after_done done=%b busy=%b result=%h want 0 0 %h",
               name, bus.done, bus.busy, bus.result, exp);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b000; bus.op_a = '0; bus.op_b = '0;
    #12;
    n_total++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0)
      $display("FAIL reset outputs stall=%b busy=%b done=%b result=%h want 0 0 0 0",
               bus.stall, bus.busy, bus.done, bus.result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh");
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, "mulhsu");
  endtask

  task automatic test_div();
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_-7/2");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_-7/2");
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_100/7");
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu_100/7");
  endtask

  task automatic test_special();
    do_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
    do_op(3'b110, 32'd5, 32'd0, 32'd5, 1, "rem_by0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
  endtask

  task automatic test_flush();
    int lat;
    int seen_done;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    seen_done = 0;
    for (int i = 1; i < 10; i++) begin
      if (bus.done === 1'b1) seen_done++;
      @(negedge clk);
    end
    bus.flush = 1'b1; bus.start = 1'b1; bus.funct3 = 3'b000;
    bus.op_a = 32'd12345; bus.op_b = 32'd1000;
    #1;
    if (bus.done === 1'b1) seen_done++;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || seen_done != 0 || bus.done !== 1'b0)
      $display("FAIL flush_div busy=%b dones=%0d want 0 0", bus.busy, seen_done);
    else n_pass++;
    bus.flush = 1'b0;
    #1;
    n_total++;
    if (bus.stall !== 1'b1) $display("FAIL flush_reaccept stall got %b want 1", bus.stall);
    else n_pass++;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_total++;
    if (lat != 33 || bus.result !== 32'd12345000)
      $display("FAIL flush_then_mul lat=%0d result=%h want 33 %h", lat, bus.result, 32'd12345000);
    else n_pass++;
    @(negedge clk);
    // Redirect arriving in the DONE cycle of a fast-path divide.
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.op_a = 32'd9; bus.op_b = 32'd0;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b1;
    #1;
    n_total++;
    if (bus.done !== 1'b0) $display("FAIL flush_in_done done got %b want 0", bus.done);
    else n_pass++;
    @(negedge clk);
    bus.flush = 1'b0;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL flush_in_done_after busy=%b done=%b want 0 0", bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL midmul_busy got %b want 1", bus.busy);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0)
      $display("FAIL midmul_reset stall=%b busy=%b done=%b result=%h want 0 0 0 0",
               bus.stall, bus.busy, bus.done, bus.result);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int d1;
    int d2;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.op_a = 32'd6; bus.op_b = 32'd7;
    @(negedge clk);
    bus.funct3 = 3'b011; bus.op_a = 32'h0001_0000; bus.op_b = 32'h0001_0000;
    cyc = 1; d1 = 0; d2 = 0;
    while (cyc < 80 && d2 == 0) begin
      if (bus.done === 1'b1) begin
        if (d1 == 0) begin
          d1 = cyc;
          n_total++;
          if (bus.result !== 32'd42) $display("FAIL b2b_first result got %h want %h", bus.result, 32'd42);
          else n_pass++;
        end else begin
          d2 = cyc;
          n_total++;
          if (bus.result !== 32'h1) $display("FAIL b2b_second result got %h want 1", bus.result);
          else n_pass++;
        end
      end
      if (d1 != 0 && cyc == d1 + 1) begin
        n_total++;
        if (bus.stall !== 1'b1 || bus.busy !== 1'b0)
          $display("FAIL b2b_accept stall=%b busy=%b want 1 0", bus.stall, bus.busy);
        else n_pass++;
      end
      if (d1 != 0 && cyc == d1 + 2) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_total++;
    if (d1 != 33 || d2 != 67)
      $display("FAIL b2b_timing first=%0d second=%0d want 33 67", d1, d2);
    else n_pass++;
    bus.start = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting in the EX stage beside the main ALU.
- Decode selects it for R-type instructions with Funct7 = 7'b0000001; Funct3 selects the M-extension operation.
- It accepts one operation at a time, stalls the pipeline while iterating, and returns a one-cycle-valid result.
- It owns the shared shift/add/subtract datapath and handles RISC-V divide-by-zero and overflow special cases.

Parameters:
- XLEN, 32, operand/result width. The iteration counter is $clog2(XLEN) bits wide.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  EX holds a valid M-extension instruction.
- flush  in  1  pipeline flush (branch/jump redirect); aborts the current operation.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value.
- op_b  in  XLEN  rs2 value.
- stall  out  1  freeze IF/ID/EX.
- busy  out  1  FSM not in IDLE.
- done  out  1  result valid this cycle.
- result  out  XLEN  operation result; valid only while done=1.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - On rst_n=0: state=IDLE; stall=0, busy=0, done=0, result=0; all internal registers cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE with start=1 and flush=0 (accept cycle):
  - Latch funct3 and operand signs.
  - Latch magnitudes per operation:
    - MUL/MULH: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU, DIVU, REMU: both unsigned.
    - DIV, REM: both signed.
  - count = XLEN-1.
  - Next state: MUL for funct3[2]=0, DIV for funct3[2]=1.
  - Fast paths go directly to DONE:
    - op_b=0: quotient = all ones; remainder = op_a.
    - Signed DIV/REM with op_a = 0x80000000 and op_b = 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- MUL: shift-add, one bit of the multiplier per cycle into a 2*XLEN product register. After the count=0 iteration, go to DONE.
- DIV: restoring division, one quotient bit per cycle (shift remainder, trial subtract, restore on negative). After the count=0 iteration, go to DONE.
- DONE:
  - Apply the sign fix-up: negate the product if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Select the output:
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - done=1 for exactly one cycle; the result register holds its value after done.
  - Next state: IDLE unconditionally. start is ignored in DONE.
- Latency:
  - Normal path: done asserted XLEN+1 cycles after the accept cycle (33 for XLEN=32).
  - Fast path: done asserted 1 cycle after accept.
- stall = start & (state==IDLE) & ~flush, OR state is MUL or DIV.
  - stall=0 in DONE, so the pipeline advances while consuming result.
  - Back-to-back: the next instruction presents start in the cycle after DONE and is accepted from IDLE.
- busy = (state != IDLE).
- flush in any state: next state IDLE, done=0, no result produced; this has priority over start and over iteration. flush during DONE suppresses done.
- Async reset mid-operation: immediate IDLE; outputs go to their reset values.
- Operand changes after the accept cycle have no effect.

Test Plan:
- MUL 7 x -3 (op_b=0xFFFFFFFD): stall high for 33 cycles; done at cycle 33; result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE. MULH of the same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> done one cycle after accept, result 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in one cycle. REM of the same operands -> 0.
- flush at iteration 10 of a DIV: state IDLE next cycle, no done pulse. A new MUL with start held is accepted the following cycle and completes with the correct result.
- rst_n low mid-MUL: outputs zero immediately. Two back-to-back MULs: second accepted the cycle after the first done, and its done arrives 33 cycles later.
